// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the memory arbiter family.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;
  localparam int STATS_W    = 16;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_LOADER = 1'b1;

  // Per-port response progress: a read is GRANTED, then returns data in RESP.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RESP    = 2'd2
  } respState_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-requester grant picker: fixed priority (port 0 wins) or round-robin on lastGrant.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic req0,
  input  logic req1,
  input  logic lastGrant,
  output logic gnt0,
  output logic gnt1
);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0 && req1) begin
      // On conflict the port that did not win last time gets the slot.
      if ((FIXED_PRIO != 0) || (lastGrant == PORT_LOADER)) gnt0 = 1'b1;
      else                                                 gnt1 = 1'b1;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between the CPU (port 0) and the loader (port 1).
// Define MEM_ARB_STATS_EN to add the conflictCount/statsClear statistics ports.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic              we0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              we1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memStrobe,
  output logic              memWrite,
  output logic [DATA_W-1:0] memDataWrite,
  input  logic [DATA_W-1:0] memDataRead
`ifdef MEM_ARB_STATS_EN
  ,
  input  logic              statsClear,
  output logic [STATS_W-1:0] conflictCount
`endif
);

  logic pickGnt0;
  logic pickGnt1;
  logic lastGrant;
  logic gntWe;
  logic anyGnt;
  logic pendValid_p1;
  logic pendOwner_p1;

  mem_arb_pick #(
    .FIXED_PRIO(FIXED_PRIO)
  ) uPick (
    .req0     (req0),
    .req1     (req1),
    .lastGrant(lastGrant),
    .gnt0     (pickGnt0),
    .gnt1     (pickGnt1)
  );

  // Stage p0: grant and memory drive, combinational from the winner.
  assign gnt0   = pickGnt0 & ~reset;
  assign gnt1   = pickGnt1 & ~reset;
  assign anyGnt = gnt0 | gnt1;

  always_comb begin
    memAddr      = addr0;
    memDataWrite = '0;
    gntWe        = 1'b0;
    if (gnt1) begin
      memAddr      = addr1;
      memDataWrite = wdata1;
      gntWe        = we1;
    end else if (gnt0) begin
      memDataWrite = wdata0;
      gntWe        = we0;
    end
  end

  assign memStrobe = anyGnt & ~gntWe;
  assign memWrite  = anyGnt &  gntWe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGrant    <= PORT_LOADER;
      pendValid_p1 <= 1'b0;
      pendOwner_p1 <= PORT_CPU;
    end else begin
      if (anyGnt) lastGrant <= gnt1;
      pendValid_p1 <= memStrobe;
      if (memStrobe) pendOwner_p1 <= gnt1;
    end
  end

  // Stage p1: read response steered to the tagged owner only.
  assign rvalid0 = pendValid_p1 & (pendOwner_p1 == PORT_CPU);
  assign rvalid1 = pendValid_p1 & (pendOwner_p1 == PORT_LOADER);
  assign rdata0  = rvalid0 ? memDataRead : '0;
  assign rdata1  = rvalid1 ? memDataRead : '0;

`ifdef MEM_ARB_STATS_EN
  logic [STATS_W-1:0] conflictCnt;

  function automatic logic [STATS_W-1:0] satInc(input logic [STATS_W-1:0] v);
    return (v == '1) ? v : v + STATS_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset)              conflictCnt <= '0;
    else if (statsClear)    conflictCnt <= '0;
    else if (req0 && req1)  conflictCnt <= satInc(conflictCnt);
  end

  assign conflictCount = conflictCnt;
`endif

endmodule
